// File: rtl/banked_mp_ram.sv
// Multi-port RAM built from single-port banks selected by the low address bits.
// Each bank arbitrates its requesting ports round-robin; reads return one cycle after grant.
module banked_mp_ram #(
    parameter int NUM_PORTS  = 4,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata,
    output logic [15:0]                      conflict_cnt
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int DEPTH     = 1 << ROW_BITS;
    localparam int PORT_BITS = $clog2(NUM_PORTS);

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    logic [BSEL_W-1:0]    bank_of  [NUM_PORTS];
    logic [ROW_BITS-1:0]  row_of   [NUM_PORTS];
    logic [PORT_BITS-1:0] ptr      [NUM_BANKS];
    logic [PORT_BITS-1:0] win_port [NUM_BANKS];
    logic [NUM_BANKS-1:0] win_vld;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        if (BANK_BITS > 0) begin : g_bank
            assign bank_of[p] = addr[p*ADDR_WIDTH +: BSEL_W];
        end else begin : g_single
            assign bank_of[p] = '0;
        end
        assign row_of[p] = addr[p*ADDR_WIDTH+BANK_BITS +: ROW_BITS];
    end

    // Per bank: first requester at or after the pointer wins; nothing is granted in reset.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        win_vld = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            win_port[b] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(ptr[b]) + k) % NUM_PORTS;
                if (!win_vld[b] && rst_n && req[idx] && int'(bank_of[idx]) == b) begin
                    win_vld[b]  = 1'b1;
                    win_port[b] = PORT_BITS'(idx);
                    gnt[idx]    = 1'b1;
                end
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (win_vld[b] && we[win_port[b]]) begin
                mem[b][row_of[win_port[b]]] <= wdata[int'(win_port[b])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid       <= '0;
            rdata        <= '0;
            conflict_cnt <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr[b] <= '0;
            end
        end else begin
            rvalid <= gnt & ~we;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p] && !we[p]) begin
                    rdata[p*DATA_WIDTH +: DATA_WIDTH] <= mem[bank_of[p]][row_of[p]];
                end
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (win_vld[b]) begin
                    ptr[b] <= (win_port[b] == PORT_BITS'(NUM_PORTS-1)) ? '0 : win_port[b] + 1'b1;
                end
            end
            if (|(req & ~gnt) && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_banked_mp_ram.sv
// Bench for banked_mp_ram: directed vector table, multi-cycle corner sequences,
// then randomized traffic compared against an address-level reference model.
module tb_banked_mp_ram;

    localparam int NP = 4;
    localparam int NB = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic             clk;
    logic             rst_n;
    logic [NP-1:0]    req, we, gnt, rvalid;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata, rdata;
    logic [15:0]      conflict_cnt;

    int n_vec = 0;
    int n_mis = 0;
    int gcyc [NP];

    banked_mp_ram #(.NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [3:0]   gnt;
        logic [3:0]   rvalid;
        logic [127:0] rdata;
        logic [15:0]  cnt;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_rdata", rdata, 0);
        tick();
        rst_n = 1'b1;
    endtask

    // Hold the pending requests until each is granted; record the grant cycle per port.
    task automatic held_run(input logic [3:0] pend_in, input logic [3:0] we_in,
                            input logic [31:0] addr_in, input logic [127:0] wd_in);
        logic [3:0] pend;
        logic [3:0] g;
        pend = pend_in;
        for (int p = 0; p < NP; p++) gcyc[p] = -1;
        we    = we_in;
        addr  = addr_in;
        wdata = wd_in;
        for (int c = 0; c < 8 && pend != 0; c++) begin
            req = pend;
            @(negedge clk);
            g = gnt;
            for (int p = 0; p < NP; p++) if (g[p] && pend[p]) gcyc[p] = c;
            tick();
            pend = pend & ~g;
        end
        req = '0;
    endtask

    vec_t vecs [12];

    logic [31:0] mmem [256];
    bit          mwr  [256];
    int          mptr [NB];
    logic [3:0]  mrv;
    logic [127:0] mrd;
    int          mcnt;
    bit          pend [NP];
    logic        pwe  [NP];
    logic [7:0]  paddr[NP];
    logic [31:0] pwd  [NP];

    initial begin
        vecs[0]  = '{4'b0111, 4'b0111, {8'h00,8'h07,8'h02,8'h00}, {32'h0,32'hAF,32'h11,32'h10},
                     4'b0111, 4'b0000, 128'h0, 16'd0};
        vecs[1]  = '{4'b0111, 4'b0000, {8'h00,8'h07,8'h02,8'h00}, 128'h0,
                     4'b0111, 4'b0000, 128'h0, 16'd0};
        vecs[2]  = '{4'b0000, 4'b0000, 32'h0, 128'h0,
                     4'b0000, 4'b0111, {32'h0,32'hAF,32'h11,32'h10}, 16'd0};
        vecs[3]  = '{4'b0000, 4'b0000, 32'h0, 128'h0,
                     4'b0000, 4'b0000, {32'h0,32'hAF,32'h11,32'h10}, 16'd0};
        vecs[4]  = '{4'b0001, 4'b0001, {8'h00,8'h00,8'h00,8'h01}, {96'h0,32'h101},
                     4'b0001, 4'b0000, {32'h0,32'hAF,32'h11,32'h10}, 16'd0};
        vecs[5]  = '{4'b0010, 4'b0010, {8'h00,8'h00,8'h05,8'h00}, {64'h0,32'h105,32'h0},
                     4'b0010, 4'b0000, {32'h0,32'hAF,32'h11,32'h10}, 16'd0};
        vecs[6]  = '{4'b0100, 4'b0100, {8'h00,8'h09,8'h00,8'h00}, {32'h0,32'h109,64'h0},
                     4'b0100, 4'b0000, {32'h0,32'hAF,32'h11,32'h10}, 16'd0};
        vecs[7]  = '{4'b1000, 4'b0000, {8'h02,8'h00,8'h00,8'h00}, 128'h0,
                     4'b1000, 4'b0000, {32'h0,32'hAF,32'h11,32'h10}, 16'd0};
        vecs[8]  = '{4'b0000, 4'b0000, 32'h0, 128'h0,
                     4'b0000, 4'b1000, {32'h11,32'hAF,32'h11,32'h10}, 16'd0};
        // Bank 0 pointer sits at 1 here, so P1 beats P0.
        vecs[9]  = '{4'b0011, 4'b0001, {8'h00,8'h00,8'h00,8'h0C}, {96'h0,32'h10C},
                     4'b0010, 4'b0000, {32'h11,32'hAF,32'h11,32'h10}, 16'd0};
        vecs[10] = '{4'b0001, 4'b0001, {8'h00,8'h00,8'h00,8'h0C}, {96'h0,32'h10C},
                     4'b0001, 4'b0010, {32'h11,32'hAF,32'h10,32'h10}, 16'd1};
        vecs[11] = '{4'b0000, 4'b0000, 32'h0, 128'h0,
                     4'b0000, 4'b0000, {32'h11,32'hAF,32'h10,32'h10}, 16'd1};

        rst_n = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        #2;
        rst_n = 1'b0;
        req   = '1;
        @(negedge clk);
        check("reset_gnt_with_req", gnt, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_rdata", rdata, 0);
        check("reset_cnt", conflict_cnt, 0);
        tick();
        rst_n = 1'b1;
        req   = '0;

        for (int i = 0; i < 12; i++) begin
            req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
            check($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].rvalid);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
            check($sformatf("vec%0d_cnt", i), conflict_cnt, vecs[i].cnt);
            tick();
        end
        req = '0;

        // Three ports contend for bank 1 straight out of reset.
        do_reset();
        held_run(4'b0111, 4'b0000, {8'h00,8'h09,8'h05,8'h01}, 128'h0);
        check("contend_p0_cycle", gcyc[0], 0);
        check("contend_p1_cycle", gcyc[1], 1);
        check("contend_p2_cycle", gcyc[2], 2);
        @(negedge clk);
        check("contend_rvalid", rvalid, 4'b0100);
        check("contend_rdata_p2", rdata[2*DW +: DW], 32'h109);
        check("contend_cnt", conflict_cnt, 2);
        tick();

        // Bank 1 pointer is now 3: P3 must beat P0.
        held_run(4'b1001, 4'b1000, {8'h0D,8'h00,8'h00,8'h01}, {32'h10D,96'h0});
        check("wrap_p3_cycle", gcyc[3], 0);
        check("wrap_p0_cycle", gcyc[0], 1);
        @(negedge clk);
        check("wrap_rvalid", rvalid, 4'b0001);
        check("wrap_rdata_p0", rdata[0 +: DW], 32'h101);
        check("wrap_cnt", conflict_cnt, 3);
        tick();

        // Write and read of the same word in the same cycle.
        do_reset();
        held_run(4'b1001, 4'b0001, {8'h07,8'h00,8'h00,8'h07}, {96'h0,32'hDEADBEEF});
        check("wtr_p0_cycle", gcyc[0], 0);
        check("wtr_p3_cycle", gcyc[3], 1);
        @(negedge clk);
        check("wtr_rvalid", rvalid, 4'b1000);
        check("wtr_rdata_p3", rdata[3*DW +: DW], 32'hDEADBEEF);
        check("wtr_cnt", conflict_cnt, 1);
        tick();

        // Reset lands in the cycle a read is being granted.
        req = 4'b0010; we = '0; addr = {8'h00,8'h00,8'h00,8'h00};
        @(negedge clk);
        check("mid_p1_gnt", gnt, 4'b0010);
        tick();
        req = 4'b0100; addr = {8'h00,8'h02,8'h00,8'h00};
        @(negedge clk);
        check("mid_p2_gnt", gnt, 4'b0100);
        check("mid_p1_rvalid", rvalid, 4'b0010);
        check("mid_p1_rdata", rdata[1*DW +: DW], 32'h10);
        #1;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_cnt", conflict_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        req = 4'b1101; addr = {8'h00,8'h07,8'h00,8'h00};
        @(negedge clk);
        check("post_rst_gnt", gnt, 4'b0101);
        check("post_rst_rvalid", rvalid, 0);
        check("post_rst_cnt", conflict_cnt, 0);
        tick();
        req = 4'b1000;
        @(negedge clk);
        check("post_rst_gnt2", gnt, 4'b1000);
        check("post_rst_rvalid2", rvalid, 4'b0101);
        check("post_rst_cnt2", conflict_cnt, 1);
        tick();
        req = '0;
        @(negedge clk);
        check("post_rst_rvalid3", rvalid, 4'b1000);
        check("post_rst_rdata", rdata, {32'h10, 32'hDEADBEEF, 32'h0, 32'h10});
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 256; i++) mwr[i] = 0;
        for (int b = 0; b < NB; b++) mptr[b] = 0;
        for (int p = 0; p < NP; p++) pend[p] = 0;
        mrv = '0; mrd = '0; mcnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [3:0] eg;
            logic [3:0] nrv;
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 9) < 7) begin
                    paddr[p] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                           : 8'($urandom_range(0, 255));
                    pwe[p]   = !mwr[paddr[p]] || ($urandom_range(0, 1) == 1);
                    pwd[p]   = $urandom;
                    pend[p]  = 1;
                end
                req[p] = pend[p];
                we[p]  = pend[p] ? pwe[p] : 1'($urandom_range(0, 1));
                addr[p*AW +: AW]  = pend[p] ? paddr[p] : 8'($urandom_range(0, 255));
                wdata[p*DW +: DW] = pend[p] ? pwd[p] : $urandom;
            end
            eg = '0;
            for (int b = 0; b < NB; b++) begin
                for (int k = 0; k < NP; k++) begin
                    int q;
                    q = (mptr[b] + k) % NP;
                    if (pend[q] && (paddr[q] % NB) == b) begin
                        eg[q]   = 1'b1;
                        mptr[b] = (q + 1) % NP;
                        break;
                    end
                end
            end
            @(negedge clk);
            check("rand_gnt", gnt, eg);
            check("rand_rvalid", rvalid, mrv);
            check("rand_rdata", rdata, mrd);
            check("rand_cnt", conflict_cnt, 16'(mcnt));
            nrv = '0;
            for (int p = 0; p < NP; p++) begin
                if (eg[p] && !pwe[p]) begin
                    nrv[p] = 1'b1;
                    mrd[p*DW +: DW] = mmem[paddr[p]];
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (eg[p] && pwe[p]) begin
                    mmem[paddr[p]] = pwd[p];
                    mwr[paddr[p]]  = 1;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (pend[p] && !eg[p] && mcnt < 65535) begin
                    mcnt++;
                    break;
                end
            end
            for (int p = 0; p < NP; p++) if (eg[p]) pend[p] = 0;
            mrv = nrv;
            tick();
        end
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
